aes_enc_ctrl: RTL and testbench

Controller for the pipelined AES-128 encryption datapath built from enc_round stages. It loads the 11 round keys into the rounds over the shared rkey/addr bus and admits plaintext blocks with a valid/ready handshake. It tracks blocks in flight through the fixed-latency pipeline and captures results into an internal output FIFO. A credit scheme keeps the FIFO from overflowing, because the rounds themselves have no stall.

---
 rtl/aes_enc_ctrl.sv | 124 ++++++++++++
 tb/tb_aes_enc_ctrl.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_enc_ctrl.sv
// Control for the pipelined AES-128 encryptor: round-key loading, plaintext admission,
// in-flight tracking and a credit-limited output FIFO for a pipeline that cannot stall.
module aes_enc_ctrl #(
  parameter int PIPE_LAT  = 20,
  parameter int OUT_DEPTH = 4,
  parameter int NUM_RKEYS = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [3:0]   key_addr,
  input  logic [127:0] key_data,
  output logic [3:0]   addr,
  output logic [127:0] rkey,
  output logic         key_err,
  output logic         keys_ready,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [127:0] pipe_din,
  input  logic [127:0] pipe_dout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  localparam int DATA_W = 128;
  localparam int AW = $clog2(OUT_DEPTH);
  localparam int CW = $clog2(PIPE_LAT + OUT_DEPTH + 1);
  localparam logic [3:0] LAST_KEY = 4'(NUM_RKEYS - 1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(OUT_DEPTH);

  typedef enum logic [1:0] {KEYLOAD, RUN, DRAIN} state_t;

  state_t               state;
  logic [NUM_RKEYS-1:0] key_mask;
  logic [PIPE_LAT-1:0]  vld;
  logic [CW-1:0]        in_flight;
  logic [DATA_W-1:0]    fifo_mem [OUT_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          fifo_count;
  logic [CW:0]          credit_used;
  logic                 key_acc;
  logic                 in_acc;
  logic                 push;
  logic                 pop;

  // Credits count both buffered blocks and blocks still inside the rounds.
  assign credit_used = (CW+1)'(in_flight) + (CW+1)'(fifo_count);
  assign key_ready   = (state == KEYLOAD);
  assign in_ready    = (state == RUN) && (credit_used < DEPTH_C);
  assign key_acc     = key_valid && key_ready;
  assign in_acc      = in_valid && in_ready;
  assign push        = vld[PIPE_LAT-1];
  assign out_valid   = (fifo_count != '0);
  assign pop         = out_valid && out_ready;
  assign out_data    = fifo_mem[rd_ptr];
  assign pipe_din    = in_data;
  assign keys_ready  = &key_mask;
  assign busy        = (in_flight != '0) || out_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= KEYLOAD;
      key_mask <= '0;
      addr     <= 4'hF;
      rkey     <= '0;
      key_err  <= 1'b0;
    end else begin
      addr    <= 4'hF;
      key_err <= 1'b0;
      if (key_acc) begin
        if (key_addr <= LAST_KEY) begin
          addr               <= key_addr;
          rkey               <= key_data;
          key_mask[key_addr] <= 1'b1;
        end else begin
          key_err <= 1'b1;
        end
      end
      case (state)
        KEYLOAD: if (keys_ready && !key_valid) state <= RUN;
        RUN:     if (key_valid) state <= DRAIN;
        DRAIN:   if (in_flight == '0) state <= KEYLOAD;
        default: state <= KEYLOAD;
      endcase
    end
  end

  // ---- stage boundary: pipeline occupancy, one bit per round-pipe slot ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld       <= '0;
      in_flight <= '0;
    end else begin
      vld <= (vld << 1) | PIPE_LAT'(in_acc);
      case ({in_acc, push})
        2'b10:   in_flight <= in_flight + CW'(1);
        2'b01:   in_flight <= in_flight - CW'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

  // ---- stage boundary: pipeline output capture into the FIFO ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      fifo_count <= fifo_count + (AW+1)'(1);
      else if (!push && pop) fifo_count <= fifo_count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= pipe_dout;
  end
endmodule

// File: tb/tb_aes_enc_ctrl.sv
// Bench for aes_enc_ctrl: emulates the AES round pipeline from the key bus and scores
// ciphertexts against a plain AES-128 reference with a queue-based scoreboard.
module tb_aes_enc_ctrl;
  localparam int PIPE_LAT  = 20;
  localparam int OUT_DEPTH = 4;
  localparam int NUM_RKEYS = 11;
  localparam int KS_W      = 128 * 11;

  logic         clk;
  logic         rst;
  logic         key_valid;
  logic         key_ready;
  logic [3:0]   key_addr;
  logic [127:0] key_data;
  logic [3:0]   addr;
  logic [127:0] rkey;
  logic         key_err;
  logic         keys_ready;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] pipe_din;
  logic [127:0] pipe_dout;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  aes_enc_ctrl #(.PIPE_LAT(PIPE_LAT), .OUT_DEPTH(OUT_DEPTH), .NUM_RKEYS(NUM_RKEYS)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready), .key_addr(key_addr),
    .key_data(key_data), .addr(addr), .rkey(rkey), .key_err(key_err), .keys_ready(keys_ready),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .pipe_din(pipe_din),
    .pipe_dout(pipe_dout), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // AES-128 reference
  logic [7:0] sb [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] b;
      b = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      sb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  end

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = sb[s[127-8*(4*((c+r)%4)+r) -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [KS_W-1:0] ks);
    logic [127:0] s;
    s = pt ^ ks[127:0];
    for (int r = 1; r < 10; r++) s = mix_cols(sub_shift(s)) ^ ks[r*128 +: 128];
    return sub_shift(s) ^ ks[10*128 +: 128];
  endfunction

  logic [127:0] rk_set [11];

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_set[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Round pipeline stand-in: rounds latch keys off the bus, results appear PIPE_LAT edges later.
  logic [127:0]    pipe_q [PIPE_LAT];
  logic [KS_W-1:0] bus_ks = '0;
  always @(posedge clk) begin
    for (int i = PIPE_LAT - 1; i > 0; i--) pipe_q[i] <= pipe_q[i-1];
    pipe_q[0] <= pipe_din;
    if (addr < 4'(NUM_RKEYS)) bus_ks[int'(addr)*128 +: 128] <= rkey;
  end
  assign pipe_dout = aes_enc(pipe_q[PIPE_LAT-1], bus_ks);

  // Scoreboard and reference bookkeeping
  int unsigned     cyc = 0;
  logic [127:0]    exp_q [$];
  int unsigned     due_q [$];
  int              avail = 0;
  logic [KS_W-1:0] cur_ks = '0;
  bit              in_run = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      due_q.delete();
      avail = 0;
    end else begin
      while (due_q.size() > 0 && due_q[0] <= cyc) begin
        void'(due_q.pop_front());
        avail++;
      end
      chk_b("out_valid vs model", out_valid, avail > 0);
      chk_b("busy vs model", busy, (due_q.size() > 0) || (avail > 0));
      if (in_run) chk_b("in_ready vs credit", in_ready, (due_q.size() + avail) < OUT_DEPTH);
      else if (in_ready) chk_b("in_ready credit bound", 1'b1, (due_q.size() + avail) < OUT_DEPTH);
      if (due_q.size() > 0) chk_i("addr idle while in flight", int'(addr), 15);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected output: got %h, want no output", out_data);
        end else begin
          chk_w("ciphertext order", out_data, exp_q.pop_front());
        end
        if (avail > 0) avail--;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(aes_enc(in_data, cur_ks));
        due_q.push_back(cyc + 1 + PIPE_LAT);
      end
      if (key_valid && key_ready && key_addr < 4'(NUM_RKEYS))
        cur_ks[int'(key_addr)*128 +: 128] = key_data;
    end
  end

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_keys();
    for (int i = 0; i < NUM_RKEYS; i++) begin
      key_valid = 1'b1;
      key_addr  = 4'(i);
      key_data  = rk_set[i];
      @(negedge clk);
      chk_b("key_ready during load", key_ready, 1'b1);
      chk_i("addr follows accept", int'(addr), (i == 0) ? 15 : i - 1);
      chk_b("keys_ready before last key", keys_ready, 1'b0);
      step();
    end
    key_valid = 1'b0;
    @(negedge clk);
    chk_i("addr last key", int'(addr), NUM_RKEYS - 1);
    chk_w("rkey last key", rkey, rk_set[NUM_RKEYS-1]);
    chk_b("keys_ready after last", keys_ready, 1'b1);
    step();
    in_run = 1'b1;
    @(negedge clk);
    chk_i("addr idle in RUN", int'(addr), 15);
    chk_b("key_ready in RUN", key_ready, 1'b0);
    chk_b("in_ready in RUN", in_ready, 1'b1);
    step();
  endtask

  task automatic random_phase(input int n);
    repeat (n) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = rand128();
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (PIPE_LAT + OUT_DEPTH + 4) step();
    chk_b("busy after drain", busy, 1'b0);
    chk_i("scoreboard empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acc;
    bit seen;
    logic [127:0] kd;
    rst = 1'b1; key_valid = 1'b0; key_addr = 4'h0; key_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk_i("reset addr", int'(addr), 15);
    chk_w("reset rkey", rkey, '0);
    chk_b("reset key_err", key_err, 1'b0);
    chk_b("reset keys_ready", keys_ready, 1'b0);
    chk_b("reset in_ready", in_ready, 1'b0);
    chk_b("reset out_valid", out_valid, 1'b0);
    chk_b("reset key_ready", key_ready, 1'b1);
    step(); step();
    rst = 1'b1;
    step();

    // bad key address
    key_valid = 1'b1; key_addr = 4'd12; key_data = rand128();
    @(negedge clk);
    chk_b("key_ready bad addr", key_ready, 1'b1);
    step();
    key_valid = 1'b0;
    @(negedge clk);
    chk_b("key_err pulse", key_err, 1'b1);
    chk_i("addr on bad key", int'(addr), 15);
    chk_b("keys_ready on bad key", keys_ready, 1'b0);
    step();
    @(negedge clk);
    chk_b("key_err one cycle", key_err, 1'b0);
    step();

    // FIPS-197 key schedule and vector
    expand(128'h000102030405060708090a0b0c0d0e0f);
    load_keys();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 128'h00112233445566778899aabbccddeeff;
    @(negedge clk);
    chk_b("in_ready fips", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    n = 0;
    while (n <= 4 * PIPE_LAT) begin
      @(negedge clk);
      if (out_valid) break;
      n++;
    end
    chk_i("out_valid latency", n, PIPE_LAT);
    chk_w("fips ciphertext", out_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    @(negedge clk);
    chk_b("busy after pop", busy, 1'b0);
    step();

    // credit limit with a stalled consumer
    in_valid = 1'b1;
    acc = 0;
    repeat (PIPE_LAT + 10) begin
      in_data = rand128();
      @(negedge clk);
      if (in_ready) acc++;
      step();
    end
    chk_i("blocks accepted while stalled", acc, OUT_DEPTH);
    @(negedge clk);
    chk_b("in_ready stalled", in_ready, 1'b0);
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (OUT_DEPTH + 2) step();
    @(negedge clk);
    chk_b("in_ready after drain", in_ready, 1'b1);
    step();

    // rekey with blocks in flight
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = rand128();
      @(negedge clk);
      chk_b("in_ready before rekey", in_ready, 1'b1);
      step();
    end
    in_valid = 1'b0;
    key_valid = 1'b1; key_addr = 4'd5; key_data = rand128(); kd = key_data;
    @(negedge clk);
    chk_b("key_ready in RUN", key_ready, 1'b0);
    step();
    in_run = 1'b0;
    n = 1;
    while (n <= 4 * PIPE_LAT) begin
      @(negedge clk);
      if (key_ready) break;
      chk_b("in_ready while draining", in_ready, 1'b0);
      n++;
    end
    chk_i("key stall cycles", n, PIPE_LAT + 1);
    step();
    key_valid = 1'b0;
    @(negedge clk);
    chk_i("addr partial rekey", int'(addr), 5);
    chk_w("rkey partial rekey", rkey, kd);
    step();
    in_run = 1'b1;
    @(negedge clk);
    chk_i("addr idle after rekey", int'(addr), 15);
    chk_b("in_ready after rekey", in_ready, 1'b1);
    step();
    chk_i("rekey results delivered", exp_q.size(), 0);

    random_phase(300);

    // reset with blocks in flight and buffered
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = rand128();
    step();
    in_valid = 1'b0;
    repeat (PIPE_LAT + 2) step();
    in_valid = 1'b1; in_data = rand128();
    step();
    in_data = rand128();
    step();
    in_valid = 1'b0;
    step(); step();
    chk_b("out_valid before reset", out_valid, 1'b1);
    #2 rst = 1'b0;
    in_run = 1'b0;
    #1;
    chk_b("async reset out_valid", out_valid, 1'b0);
    chk_b("async reset in_ready", in_ready, 1'b0);
    chk_b("async reset busy", busy, 1'b0);
    chk_b("async reset keys_ready", keys_ready, 1'b0);
    chk_i("async reset addr", int'(addr), 15);
    chk_w("async reset rkey", rkey, '0);
    step(); step();
    rst = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (2 * PIPE_LAT) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      step();
    end
    chk_b("no output after reset", seen, 1'b0);
    chk_b("keys forgotten", keys_ready, 1'b0);

    expand(rand128());
    load_keys();
    random_phase(300);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
